// File: rtl/sramb_arb_pkg.sv
// sramb_arb_pkg
//   Shared types for the sramb arbiter slice.
//   arb_state_e : controller state, also exported on the arbiter's
//                 dbg_state port so checkers can follow the sweep/run phases.
package sramb_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,  // sweeping INIT_VAL into every word
        ST_RUN  = 1'b1   // arbitrating between the two requesters
    } arb_state_e;

endpackage

// File: rtl/sramb.sv
// sramb
//   Generic single-port synchronous SRAM with a registered read port.
//   Ports:
//     clk   in  clock
//     addr  in  word address
//     wdat  in  write data
//     rd    in  read strobe; rdat updates at the edge, visible next cycle
//     wr    in  write strobe; word updates at the edge
//     rdat  out registered read data (holds between reads)
module sramb #(
    parameter int DBITS = 12,
    parameter int DEPTH = 256,
    localparam int ABITS = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [ABITS-1:0] addr,
    input  logic [DBITS-1:0] wdat,
    input  logic             rd,
    input  logic             wr,
    output logic [DBITS-1:0] rdat
);

    logic [DBITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[addr] <= wdat;
        end
        if (rd) begin
            rdat <= mem[addr];
        end
    end

endmodule

// File: rtl/sramb_arb_top.sv
// sramb_arb_top
//   sramb_arb bolted to a generic sramb instance, giving a self-contained
//   arbitrated memory. Ports are the requester side of sramb_arb plus its
//   status outputs; the memory-side m_* bus is internal.
module sramb_arb_top
    import sramb_arb_pkg::*;
#(
    parameter int               DBITS    = 12,
    parameter int               DEPTH    = 256,
    parameter logic [DBITS-1:0] INIT_VAL = '0,
    localparam int              ABITS    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [ABITS-1:0] addr0,
    input  logic [ABITS-1:0] addr1,
    input  logic [DBITS-1:0] wdat0,
    input  logic [DBITS-1:0] wdat1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvld0,
    output logic             rvld1,
    output logic [DBITS-1:0] rdat_o,
    output logic             init_done,
    output arb_state_e       dbg_state
);

    logic [ABITS-1:0] m_addr;
    logic [DBITS-1:0] m_wdat;
    logic [DBITS-1:0] m_rdat;
    logic             m_rd;
    logic             m_wr;

    sramb_arb #(
        .DBITS    (DBITS),
        .DEPTH    (DEPTH),
        .INIT_VAL (INIT_VAL)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdat0     (wdat0),
        .wdat1     (wdat1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvld0     (rvld0),
        .rvld1     (rvld1),
        .rdat_o    (rdat_o),
        .init_done (init_done),
        .m_addr    (m_addr),
        .m_wdat    (m_wdat),
        .m_rd      (m_rd),
        .m_wr      (m_wr),
        .m_rdat    (m_rdat),
        .dbg_state (dbg_state)
    );

    sramb #(
        .DBITS (DBITS),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk  (clk),
        .addr (m_addr),
        .wdat (m_wdat),
        .rd   (m_rd),
        .wr   (m_wr),
        .rdat (m_rdat)
    );

endmodule

// File: rtl/sramb_arb.sv
// sramb_arb
//   Initialiser plus two-requester round-robin arbiter for one single-port
//   sramb instance. After reset the whole array is swept to INIT_VAL, then
//   the port is shared between requester 0 and requester 1. Read data comes
//   back one cycle after the grant with a per-requester valid strobe.
//
//   Handshake: reqN is a level held by the requester until it sees gntN high
//   in the same cycle; the access (weN/addrN/wdatN) is taken at the clock
//   edge that closes that cycle. A req still high after a grant is a fresh
//   request. Nothing is granted during the sweep or while rst is high.
//
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     req0/1, we0/1       request level, 1 = write / 0 = read
//     addr0/1, wdat0/1    per-requester address and write data
//     gnt0/1              combinational grant (same cycle as the access)
//     rvld0/1             read data valid, one cycle after a granted read
//     rdat_o              read data, valid with rvld0 or rvld1
//     init_done           high once the sweep has finished
//     m_addr/m_wdat       memory address / write data
//     m_rd/m_wr           memory read / write strobes
//     m_rdat              memory read data
//     dbg_state           current controller state
module sramb_arb
    import sramb_arb_pkg::*;
#(
    parameter int               DBITS    = 12,
    parameter int               DEPTH    = 256,
    parameter logic [DBITS-1:0] INIT_VAL = '0,
    localparam int              ABITS    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [ABITS-1:0] addr0,
    input  logic [ABITS-1:0] addr1,
    input  logic [DBITS-1:0] wdat0,
    input  logic [DBITS-1:0] wdat1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvld0,
    output logic             rvld1,
    output logic [DBITS-1:0] rdat_o,
    output logic             init_done,
    output logic [ABITS-1:0] m_addr,
    output logic [DBITS-1:0] m_wdat,
    output logic             m_rd,
    output logic             m_wr,
    input  logic [DBITS-1:0] m_rdat,
    output arb_state_e       dbg_state
);

    localparam logic [ABITS-1:0] LAST_ADDR = ABITS'(DEPTH - 1);

    arb_state_e       state, state_nxt;
    logic [ABITS-1:0] cnt, cnt_nxt;
    // Index of the requester granted most recently; the other one wins a tie.
    logic             rr_last, rr_nxt;
    // Outstanding read return: valid flag plus which requester it belongs to.
    logic             rd_pend, pend_nxt;
    logic             rd_tag, tag_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_INIT;
            cnt     <= '0;
            rr_last <= 1'b1;
            rd_pend <= 1'b0;
            rd_tag  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rr_last <= rr_nxt;
            rd_pend <= pend_nxt;
            rd_tag  <= tag_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rr_nxt    = rr_last;
        pend_nxt  = 1'b0;
        tag_nxt   = rd_tag;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        m_addr    = '0;
        m_wdat    = '0;
        m_rd      = 1'b0;
        m_wr      = 1'b0;

        // While rst is high the port stays idle; the register block ignores
        // the next-state values in that cycle anyway.
        if (!rst) begin
            case (state)
                ST_INIT: begin
                    m_wr    = 1'b1;
                    m_addr  = cnt;
                    m_wdat  = INIT_VAL;
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == LAST_ADDR) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_RUN;
                    end
                end

                ST_RUN: begin
                    // On contention the requester that did not win last time
                    // is served, which gives strict alternation.
                    gnt0 = req0 && (!req1 || rr_last);
                    gnt1 = req1 && (!req0 || !rr_last);

                    if (gnt0) begin
                        m_addr   = addr0;
                        m_wdat   = wdat0;
                        m_wr     = we0;
                        m_rd     = !we0;
                        rr_nxt   = 1'b0;
                        pend_nxt = !we0;
                        tag_nxt  = 1'b0;
                    end else if (gnt1) begin
                        m_addr   = addr1;
                        m_wdat   = wdat1;
                        m_wr     = we1;
                        m_rd     = !we1;
                        rr_nxt   = 1'b1;
                        pend_nxt = !we1;
                        tag_nxt  = 1'b1;
                    end
                end

                default: begin
                    state_nxt = ST_INIT;
                end
            endcase
        end
    end

    // A read return that lands in a reset cycle is dropped here; the pending
    // flag itself is cleared at the same edge.
    assign rvld0     = rd_pend && !rd_tag && !rst;
    assign rvld1     = rd_pend &&  rd_tag && !rst;
    assign rdat_o    = m_rdat;
    assign init_done = (state == ST_RUN) && !rst;
    assign dbg_state = state;

endmodule

// File: tb/tb_sramb_arb.sv
module tb_sramb_arb;
    import sramb_arb_pkg::*;

    localparam int               DBITS    = 12;
    localparam int               DEPTH    = 256;
    localparam int               ABITS    = 8;
    localparam logic [DBITS-1:0] INIT_VAL = 12'h000;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1, we0, we1;
    logic [ABITS-1:0] addr0, addr1;
    logic [DBITS-1:0] wdat0, wdat1;
    logic             gnt0, gnt1, rvld0, rvld1, init_done;
    logic [DBITS-1:0] rdat_o;
    logic [ABITS-1:0] m_addr;
    logic [DBITS-1:0] m_wdat;
    logic             m_rd, m_wr;
    logic [DBITS-1:0] m_rdat;
    arb_state_e       dbg_state;

    always #5 clk = ~clk;

    sramb_arb #(
        .DBITS    (DBITS),
        .DEPTH    (DEPTH),
        .INIT_VAL (INIT_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdat0     (wdat0),
        .wdat1     (wdat1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvld0     (rvld0),
        .rvld1     (rvld1),
        .rdat_o    (rdat_o),
        .init_done (init_done),
        .m_addr    (m_addr),
        .m_wdat    (m_wdat),
        .m_rd      (m_rd),
        .m_wr      (m_wr),
        .m_rdat    (m_rdat),
        .dbg_state (dbg_state)
    );

    // Bench-side memory that the DUT's m_* bus talks to.
    logic [DBITS-1:0] bench_mem [DEPTH];
    always @(posedge clk) begin
        if (m_wr) bench_mem[m_addr] <= m_wdat;
        if (m_rd) m_rdat <= bench_mem[m_addr];
    end

    // ---------------- scoreboard counters ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, want %0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Tracks: cycles of sweep done, last winner (0/1), outstanding read
    // (owner + data), and the memory contents the arbiter should have built.
    logic [DBITS-1:0] ref_mem [DEPTH];
    int               sweep     = 0;
    int               last_win  = 1;
    int               pend_tag  = -1;
    logic [DBITS-1:0] pend_data = '0;
    bit               model_on  = 0;
    int               win;
    logic             e_g0, e_g1, e_rd, e_wr;
    logic [ABITS-1:0] e_addr;
    logic [DBITS-1:0] e_wdat;

    always @(negedge clk) begin
        if (rst) model_on = 1;
        if (model_on) begin
            win = -1;
            e_g0 = 0; e_g1 = 0; e_rd = 0; e_wr = 0; e_addr = '0; e_wdat = '0;
            if (!rst) begin
                if (sweep < DEPTH) begin
                    e_wr   = 1;
                    e_addr = sweep[ABITS-1:0];
                    e_wdat = INIT_VAL;
                end else begin
                    if (req0 && req1) win = (last_win == 0) ? 1 : 0;
                    else if (req0)    win = 0;
                    else if (req1)    win = 1;
                    if (win == 0) begin
                        e_g0 = 1; e_addr = addr0; e_wdat = wdat0; e_wr = we0; e_rd = !we0;
                    end else if (win == 1) begin
                        e_g1 = 1; e_addr = addr1; e_wdat = wdat1; e_wr = we1; e_rd = !we1;
                    end
                end
            end

            check("gnt0", 32'(gnt0), 32'(e_g0));
            check("gnt1", 32'(gnt1), 32'(e_g1));
            check("m_wr", 32'(m_wr), 32'(e_wr));
            check("m_rd", 32'(m_rd), 32'(e_rd));
            check("m_addr", 32'(m_addr), 32'(e_addr));
            check("m_wdat", 32'(m_wdat), 32'(e_wdat));
            check("rvld0", 32'(rvld0), 32'(!rst && pend_tag == 0));
            check("rvld1", 32'(rvld1), 32'(!rst && pend_tag == 1));
            check("init_done", 32'(init_done), 32'(!rst && sweep >= DEPTH));
            if (!rst && pend_tag >= 0) check("rdat_o", 32'(rdat_o), 32'(pend_data));
            if (!rst) check("dbg_state", 32'(dbg_state), (sweep >= DEPTH) ? 32'(ST_RUN) : 32'(ST_INIT));

            // Advance to what the next cycle should look like.
            pend_tag = -1;
            if (rst) begin
                sweep    = 0;
                last_win = 1;
            end else if (sweep < DEPTH) begin
                ref_mem[sweep] = INIT_VAL;
                sweep++;
            end else if (win >= 0) begin
                last_win = win;
                if (e_rd) begin
                    pend_tag  = win;
                    pend_data = ref_mem[e_addr];
                end else begin
                    ref_mem[e_addr] = e_wdat;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the given grant; returns the 1-based cycle count
    // since entry, 0 if it never came.
    task automatic wait_gnt(input int which, output int n_found);
        n_found = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n == 1) check("sweep_start_addr", 32'(m_addr), 32'h0);
            if ((which == 0 && gnt0) || (which == 1 && gnt1)) begin
                n_found = n;
                break;
            end
            cyc();
        end
    endtask

    int n_found;
    int g_seq [6];
    int v_seq [6];
    int exp_seq [6] = '{0, 1, 0, 1, 0, 1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdat0 = '0; wdat1 = '0;

        // Reset with req0 held as a read of 0x37 through the whole sweep.
        req0 = 1; we0 = 0; addr0 = 8'h37;
        repeat (2) cyc();
        rst = 0;
        wait_gnt(0, n_found);
        check("first_gnt0_cycle", 32'(n_found), 32'd257);
        check("init_done_at_first_gnt", 32'(init_done), 32'h1);
        cyc(); req0 = 0;
        @(negedge clk);
        check("rd37_rvld0", 32'(rvld0), 32'h1);
        check("rd37_rvld1", 32'(rvld1), 32'h0);
        check("rd37_rdat", 32'(rdat_o), 32'h000);

        // req0 writes 0x5A5 @0x10, req1 reads it back next cycle.
        cyc(); req0 = 1; we0 = 1; addr0 = 8'h10; wdat0 = 12'h5A5;
        @(negedge clk); check("wr10_gnt0", 32'(gnt0), 32'h1);
        cyc(); req0 = 0; req1 = 1; we1 = 0; addr1 = 8'h10;
        @(negedge clk); check("rd10_gnt1", 32'(gnt1), 32'h1);
        cyc(); req1 = 0;
        @(negedge clk);
        check("rd10_rvld1", 32'(rvld1), 32'h1);
        check("rd10_rdat", 32'(rdat_o), 32'h5A5);

        // req1 writes 0x0AB @0x20, req0 reads it back.
        cyc(); req1 = 1; we1 = 1; addr1 = 8'h20; wdat1 = 12'h0AB;
        @(negedge clk); check("wr20_gnt1", 32'(gnt1), 32'h1);
        cyc(); req1 = 0; req0 = 1; we0 = 0; addr0 = 8'h20;
        @(negedge clk); check("rd20_gnt0", 32'(gnt0), 32'h1);
        cyc(); req0 = 0;
        @(negedge clk);
        check("rd20_rvld0", 32'(rvld0), 32'h1);
        check("rd20_rdat", 32'(rdat_o), 32'h0AB);

        // Two back-to-back req1 reads so requester 1 is the last winner.
        cyc(); req1 = 1; we1 = 0; addr1 = 8'h10;
        cyc();
        cyc(); req1 = 0;
        @(negedge clk);
        check("b2b_rvld1", 32'(rvld1), 32'h1);

        // Contention: both read for 6 cycles.
        cyc(); req0 = 1; we0 = 0; addr0 = 8'h10; req1 = 1; we1 = 0; addr1 = 8'h20;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 6) g_seq[i] = gnt0 ? 0 : (gnt1 ? 1 : 9);
            if (i >= 1) v_seq[i-1] = rvld0 ? 0 : (rvld1 ? 1 : 9);
            cyc();
            if (i == 5) begin req0 = 0; req1 = 0; end
        end
        for (int i = 0; i < 6; i++) begin
            check($sformatf("contend_gnt[%0d]", i), 32'(g_seq[i]), 32'(exp_seq[i]));
            check($sformatf("contend_rvld[%0d]", i), 32'(v_seq[i]), 32'(exp_seq[i]));
        end

        // Reset in the middle of a sweep at counter 100.
        rst = 1; cyc(); rst = 0;
        repeat (100) cyc();
        @(negedge clk);
        check("sweep_addr_100", 32'(m_addr), 32'd100);
        cyc(); rst = 1;
        req1 = 1; we1 = 0; addr1 = 8'h37;
        @(negedge clk);
        check("rst_mid_sweep_m_wr", 32'(m_wr), 32'h0);
        cyc(); rst = 0;
        wait_gnt(1, n_found);
        check("restart_first_gnt1_cycle", 32'(n_found), 32'd257);
        cyc(); req1 = 0;
        @(negedge clk);
        check("restart_rvld1", 32'(rvld1), 32'h1);
        check("restart_rdat", 32'(rdat_o), 32'h000);

        // Granted read followed by reset: the return is discarded.
        cyc(); req0 = 1; we0 = 0; addr0 = 8'h05;
        @(negedge clk); check("rd05_gnt0", 32'(gnt0), 32'h1);
        cyc(); req0 = 0; rst = 1;
        @(negedge clk);
        check("rst_drop_rvld0", 32'(rvld0), 32'h0);
        check("rst_drop_rvld1", 32'(rvld1), 32'h0);
        cyc(); rst = 0;
        @(negedge clk);
        check("post_rst_rvld0", 32'(rvld0), 32'h0);
        check("post_rst_rvld1", 32'(rvld1), 32'h0);
        repeat (3) cyc();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sramb_arb.md
Name: sramb_arb

Overview:
- Two-requester round-robin arbiter and initialiser for one single-port synchronous SRAM instance (sramb, 1-cycle registered read).
- After reset it sweeps the whole array to INIT_VAL, then shares the single port between requester 0 (e.g. baseband write path) and requester 1 (e.g. readback/debug path).
- Returns read data to the granted requester with a valid strobe.
- Sits between the baseband datapath and the sramb instance.

Parameters:
- DBITS, 12, data width; must match the sramb instance.
- DEPTH, 256, words; ABITS = $clog2(DEPTH) as localparam.
- INIT_VAL, 0, DBITS-wide value written to every word after reset.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- req0, req1  in  1  access request, level, held until granted.
- we0, we1  in  1  1 = write, 0 = read; sampled with the request.
- addr0, addr1  in  ABITS  word address.
- wdat0, wdat1  in  DBITS  write data.
- gnt0, gnt1  out  1  combinational grant, same cycle as the access.
- rvld0, rvld1  out  1  read data valid, one cycle after a granted read.
- rdat_o  out  DBITS  read data, valid when rvld0 or rvld1 is high.
- init_done  out  1  high once the initialisation sweep has finished.
- m_addr  out  ABITS  to sramb addr.
- m_wdat  out  DBITS  to sramb wdat.
- m_rd, m_wr  out  1  to sramb rd and wr.
- m_rdat  in  DBITS  from sramb rdat.

Behaviour:
- FSM has two states, INIT and RUN.
- Reset (any cycle, including mid-sweep or mid-read):
  - state=INIT, sweep counter=0, rr_last=1 (requester 0 wins first), rvld0=rvld1=0, init_done=0.
  - A pending read return is discarded.
- INIT:
  - Each cycle: m_wr=1, m_rd=0, m_addr=counter, m_wdat=INIT_VAL; counter increments.
  - At counter==DEPTH-1 the write is issued and the next state is RUN.
  - The sweep takes exactly DEPTH cycles; init_done rises on the first RUN cycle.
  - gnt0=gnt1=0 throughout; requests wait without error.
- RUN, grant is combinational:
  - Only req0 -> gnt0. Only req1 -> gnt1.
  - Both -> grant the requester that is not rr_last.
  - rr_last updates to the granted index at the clock edge. No grant -> rr_last holds.
  - At most one grant per cycle.
  - Granted access drives m_addr/m_wdat from the winner, m_wr=we, m_rd=!we.
  - With no grant, m_rd=m_wr=0 and m_addr/m_wdat are don't-care (drive 0).
- Read return:
  - A granted read registers a one-bit tag (winner) and a valid flag.
  - Next cycle rvld[tag]=1 for exactly one cycle; rdat_o=m_rdat combinationally.
  - Latency is 1 cycle from the gnt edge.
  - Back-to-back reads from alternating requesters return on consecutive cycles.
- Write then read of the same address on consecutive cycles returns the new data, since the write completes at the edge before the read.
- A requester holding req after gnt is treated as a new request next cycle. Back-to-back accesses from one requester are allowed when the other is idle.
- Fairness: under continuous contention, grants alternate strictly 0,1,0,1.
- Address range is not checked; addresses >= DEPTH when DEPTH is not a power of two are undefined.

Decomposition:
- No shared package needed; ABITS is a localparam.
- Single sub-module: instantiate sramb inside a wrapper, sramb_arb_top, for verification.
- sramb_arb itself exposes the m_* port so it can drive either the generic sramb or the FPGA RAM macro.

Test Plan:
- Reset, hold req0=1: m_wr=1 for 256 cycles, addresses 0..255 with data 0; gnt0 first asserts on cycle 257 together with init_done=1.
- After init, read addr 0x37 via req0 -> rvld0=1 next cycle, rdat_o=0x000; rvld1 stays 0.
- req0 write 0x5A5 to 0x10, next cycle req1 reads 0x10 -> gnt1, then rvld1 with rdat_o=0x5A5.
- req0 and req1 both held for 6 cycles, all reads -> grants 0,1,0,1,0,1; rvld pulses follow the same order, each 1 cycle later.
- Assert rst for 1 cycle during the sweep at counter=100: sweep restarts at address 0 and still takes 256 cycles.
- Granted read, then rst on the next cycle: rvld0=rvld1=0 in that cycle and afterwards.
